// File: rtl/bus_demux4.sv
// One-to-four request router: decodes the slave from address bits, runs a
// valid/ready handshake to that slave only, and bounds each access with a timeout.
module bus_demux4 #(
    parameter int unsigned SEL_LSB = 28,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m_req_valid,
    output logic        m_req_ready,
    input  logic [31:0] m_addr,
    input  logic        m_we,
    input  logic [31:0] m_wdata,
    output logic        m_resp_valid,
    output logic [31:0] m_rdata,
    output logic        m_err,
    output logic [3:0]  s_valid,
    output logic [31:0] s_addr,
    output logic        s_we,
    output logic [31:0] s_wdata,
    input  logic [3:0]  s_ready,
    input  logic [31:0] s_rdata0,
    input  logic [31:0] s_rdata1,
    input  logic [31:0] s_rdata2,
    input  logic [31:0] s_rdata3
);

    localparam int unsigned HI_LSB = SEL_LSB + 2;
    localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       sel;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      sel_rdata_c;
    logic             sel_ready_c;
    logic             dec_err_c;

    // Ready is decoded from state so it returns to 1 the instant reset asserts.
    assign m_req_ready = (state == IDLE);

    // Any address bit above the select field means no slave exists there.
    assign dec_err_c   = ((m_addr >> HI_LSB) != 32'd0);
    assign sel_ready_c = s_ready[sel];

    always_comb begin
        sel_rdata_c = s_rdata0;
        case (sel)
            2'd0:    sel_rdata_c = s_rdata0;
            2'd1:    sel_rdata_c = s_rdata1;
            2'd2:    sel_rdata_c = s_rdata2;
            default: sel_rdata_c = s_rdata3;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sel          <= 2'd0;
            cnt          <= '0;
            s_valid      <= 4'd0;
            s_addr       <= 32'd0;
            s_we         <= 1'b0;
            s_wdata      <= 32'd0;
            m_resp_valid <= 1'b0;
            m_rdata      <= 32'd0;
            m_err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m_req_valid) begin
                        s_addr  <= m_addr;
                        s_we    <= m_we;
                        s_wdata <= m_wdata;
                        sel     <= m_addr[SEL_LSB +: 2];
                        cnt     <= '0;
                        if (dec_err_c) begin
                            state        <= RESP;
                            m_resp_valid <= 1'b1;
                            m_err        <= 1'b1;
                            m_rdata      <= 32'd0;
                        end else begin
                            state   <= WAIT;
                            s_valid <= 4'(4'b0001 << m_addr[SEL_LSB +: 2]);
                        end
                    end
                end
                WAIT: begin
                    // A ready in the final allowed cycle still completes cleanly.
                    if (sel_ready_c) begin
                        state        <= RESP;
                        s_valid      <= 4'd0;
                        m_resp_valid <= 1'b1;
                        m_err        <= 1'b0;
                        m_rdata      <= sel_rdata_c;
                    end else if (cnt == CNT_LAST) begin
                        state        <= RESP;
                        s_valid      <= 4'd0;
                        m_resp_valid <= 1'b1;
                        m_err        <= 1'b1;
                        m_rdata      <= 32'd0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state        <= IDLE;
                    m_resp_valid <= 1'b0;
                    s_valid      <= 4'd0;
                end
                default: begin
                    state        <= IDLE;
                    m_resp_valid <= 1'b0;
                    s_valid      <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_demux4.sv
// Directed, table-driven bench for bus_demux4 with a behavioural slave model
// plus hand-written reset sequences.
module tb_bus_demux4;

    logic        clk;
    logic        rst_n;
    logic        m_req_valid;
    logic        m_req_ready;
    logic [31:0] m_addr;
    logic        m_we;
    logic [31:0] m_wdata;
    logic        m_resp_valid;
    logic [31:0] m_rdata;
    logic        m_err;
    logic [3:0]  s_valid;
    logic [31:0] s_addr;
    logic        s_we;
    logic [31:0] s_wdata;
    logic [3:0]  s_ready;
    logic [31:0] s_rdata0;
    logic [31:0] s_rdata1;
    logic [31:0] s_rdata2;
    logic [31:0] s_rdata3;

    int n_total;
    int n_pass;

    bus_demux4 #(.SEL_LSB(28), .TIMEOUT(15)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m_req_valid  (m_req_valid),
        .m_req_ready  (m_req_ready),
        .m_addr       (m_addr),
        .m_we         (m_we),
        .m_wdata      (m_wdata),
        .m_resp_valid (m_resp_valid),
        .m_rdata      (m_rdata),
        .m_err        (m_err),
        .s_valid      (s_valid),
        .s_addr       (s_addr),
        .s_we         (s_we),
        .s_wdata      (s_wdata),
        .s_ready      (s_ready),
        .s_rdata0     (s_rdata0),
        .s_rdata1     (s_rdata1),
        .s_rdata2     (s_rdata2),
        .s_rdata3     (s_rdata3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          slv;        // slave whose ready the model drives
        int          rdy_after;  // WAIT cycles before that ready rises
        logic [3:0]  bg;         // non-target ready bits held high throughout
        logic [31:0] srdata;     // read data presented by the target slave
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_sv;
        int          exp_wait;   // cycles s_valid is high
        int          exp_lat;    // edges from accept until m_resp_valid
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [3:0] mask;
        int lat;
        int sv_cycles;
        bit sv_bad;
        mask = 4'(1 << v.slv);
        s_rdata0 = 32'hFFFF_FFFF;
        s_rdata1 = 32'hFFFF_FFFF;
        s_rdata2 = 32'hFFFF_FFFF;
        s_rdata3 = 32'hFFFF_FFFF;
        case (v.slv)
            0: s_rdata0 = v.srdata;
            1: s_rdata1 = v.srdata;
            2: s_rdata2 = v.srdata;
            default: s_rdata3 = v.srdata;
        endcase
        s_ready     = 4'd0;
        m_req_valid = 1'b1;
        m_addr      = v.addr;
        m_we        = v.we;
        m_wdata     = v.wdata;
        chk({tag, " ready_before"}, 32'(m_req_ready), 32'd1);
        tick();
        m_req_valid = 1'b0;
        m_addr      = 32'h0BAD_0BAD;
        m_wdata     = 32'h0BAD_0BAD;
        lat = 0;
        sv_cycles = 0;
        sv_bad = 1'b0;
        while (!m_resp_valid && lat < 40) begin
            if (s_valid !== v.exp_sv) sv_bad = 1'b1;
            sv_cycles++;
            s_ready = v.bg | ((sv_cycles > v.rdy_after) ? mask : 4'd0);
            tick();
            lat++;
        end
        chk({tag, " s_valid_steady"}, 32'(sv_bad), 32'd0);
        chk({tag, " wait_cycles"}, 32'(sv_cycles), 32'(v.exp_wait));
        chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, " resp_valid"}, 32'(m_resp_valid), 32'd1);
        chk({tag, " err"}, 32'(m_err), 32'(v.exp_err));
        chk({tag, " rdata"}, m_rdata, v.exp_rdata);
        chk({tag, " s_valid_in_resp"}, 32'(s_valid), 32'd0);
        chk({tag, " s_addr"}, s_addr, v.addr);
        chk({tag, " s_we"}, 32'(s_we), 32'(v.we));
        chk({tag, " s_wdata"}, s_wdata, v.wdata);
        s_ready = 4'd0;
        tick();
        chk({tag, " resp_pulse_len"}, 32'(m_resp_valid), 32'd0);
        chk({tag, " ready_after"}, 32'(m_req_ready), 32'd1);
        chk({tag, " rdata_hold"}, m_rdata, v.exp_rdata);
    endtask

    initial begin
        int resp_seen;
        n_total = 0;
        n_pass  = 0;

        //            addr          we    wdata         slv rdy bg       srdata        err   rdata         sv       wt  lat
        vecs[0] = '{32'h2000_0010, 1'b0, 32'h0000_0000, 2, 0,  4'b0000, 32'hCAFE_0002, 1'b0, 32'hCAFE_0002, 4'b0100, 1,  1};
        vecs[1] = '{32'h1000_0004, 1'b1, 32'h1234_5678, 1, 3,  4'b0000, 32'h5555_AAAA, 1'b0, 32'h5555_AAAA, 4'b0010, 4,  4};
        vecs[2] = '{32'h4000_0000, 1'b0, 32'h0000_0000, 0, 0,  4'b0000, 32'h1111_1111, 1'b1, 32'h0000_0000, 4'b0000, 0,  0};
        vecs[3] = '{32'h3000_0000, 1'b0, 32'h0000_0000, 3, 99, 4'b0111, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000, 4'b1000, 15, 15};
        vecs[4] = '{32'h3000_0008, 1'b0, 32'h0000_0000, 3, 14, 4'b0000, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 4'b1000, 15, 15};
        vecs[5] = '{32'h0000_0100, 1'b0, 32'h0000_0000, 0, 1,  4'b1110, 32'h0000_00A5, 1'b0, 32'h0000_00A5, 4'b0001, 2,  2};
        vecs[6] = '{32'h8000_0000, 1'b1, 32'hA5A5_A5A5, 0, 0,  4'b0000, 32'h2222_2222, 1'b1, 32'h0000_0000, 4'b0000, 0,  0};
        vecs[7] = '{32'h1FFF_FFFC, 1'b0, 32'h0000_0000, 1, 0,  4'b0000, 32'h7777_0001, 1'b0, 32'h7777_0001, 4'b0010, 1,  1};

        rst_n       = 1'b1;
        m_req_valid = 1'b0;
        m_addr      = 32'd0;
        m_we        = 1'b0;
        m_wdata     = 32'd0;
        s_ready     = 4'd0;
        s_rdata0    = 32'hFFFF_FFFF;
        s_rdata1    = 32'hFFFF_FFFF;
        s_rdata2    = 32'hFFFF_FFFF;
        s_rdata3    = 32'hFFFF_FFFF;
        #3 rst_n = 1'b0;
        #20;

        // Reset values
        chk("rst m_req_ready", 32'(m_req_ready), 32'd1);
        chk("rst m_resp_valid", 32'(m_resp_valid), 32'd0);
        chk("rst m_err", 32'(m_err), 32'd0);
        chk("rst m_rdata", m_rdata, 32'd0);
        chk("rst s_valid", 32'(s_valid), 32'd0);
        chk("rst s_addr", s_addr, 32'd0);
        chk("rst s_we", 32'(s_we), 32'd0);
        chk("rst s_wdata", s_wdata, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst ready", 32'(m_req_ready), 32'd1);
        chk("post_rst s_valid", 32'(s_valid), 32'd0);

        for (int i = 0; i < 8; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset in the second WAIT cycle drops the transaction silently
        s_ready     = 4'd0;
        m_req_valid = 1'b1;
        m_addr      = 32'h2000_0020;
        m_we        = 1'b0;
        tick();
        m_req_valid = 1'b0;
        tick();
        chk("midrst s_valid_before", 32'(s_valid), 32'h4);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst s_valid_async", 32'(s_valid), 32'd0);
        chk("midrst ready_async", 32'(m_req_ready), 32'd1);
        chk("midrst s_addr", s_addr, 32'd0);
        chk("midrst m_rdata", m_rdata, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        resp_seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (m_resp_valid || s_valid != 4'd0) resp_seen++;
            tick();
        end
        chk("midrst no_response", 32'(resp_seen), 32'd0);
        run_vec('{32'h0000_0040, 1'b0, 32'h0, 0, 0, 4'b0000, 32'h600D_0000,
                  1'b0, 32'h600D_0000, 4'b0001, 1, 1}, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
